// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared PS/2 host-path types and constants (tx and rx paths).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam int c_INHIBIT_CYC_DEFAULT = 5000;    // 100 us at 50 MHz
    localparam int c_TIMEOUT_CYC_DEFAULT = 750000;  // 15 ms at 50 MHz
    localparam int c_BIT_CNT_W           = 4;
    localparam int c_STATE_W             = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// ============================================================================
//  Module   : ps2_host_tx_if
//  Brief    : Byte request / completion handshake of the PS/2 host transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, err, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, err, busy
    );

endinterface

`default_nettype wire

// File: rtl/ps2_sync.sv
// ============================================================================
//  Module   : ps2_sync
//  Brief    : Two-flop synchronizer for PS/2 clock/data plus clock falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_sync (
    input  wire logic clk,
    input  wire logic clr,
    input  wire logic i_ps2_clk,
    input  wire logic i_ps2_data,
    output logic      o_clk_sync,
    output logic      o_data_sync,
    output logic      o_clk_fe
);

    logic [1:0] r_clk_ff;
    logic [1:0] r_data_ff;
    logic       r_clk_prev;

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_clk_ff   <= 2'b11;
            r_data_ff  <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_ff   <= {r_clk_ff[0], i_ps2_clk};
            r_data_ff  <= {r_data_ff[0], i_ps2_data};
            r_clk_prev <= r_clk_ff[1];
        end
    end

    assign o_clk_sync  = r_clk_ff[1];
    assign o_data_sync = r_data_ff[1];
    assign o_clk_fe    = r_clk_prev & ~r_clk_ff[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : PS/2 host-to-device byte transmitter (inhibit, RTS, frame, ack).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = c_INHIBIT_CYC_DEFAULT,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     clr,
    input  wire logic     ps2_clk_i,
    input  wire logic     ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe,
    ps2_host_tx_if.slave  tx_if
);

    localparam int c_INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_INH_W-1:0]     c_INH_LAST   = c_INH_W'(INHIBIT_CYC - 1);
    localparam logic [c_TMO_W-1:0]     c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_PARITY = c_BIT_CNT_W'(8);

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fe;
    logic w_active;
    logic w_accept;

    ps2_state_t               r_state;
    logic [7:0]               r_shift;
    logic                     r_parity;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic [c_INH_W-1:0]       r_inh_cnt;
    logic [c_TMO_W-1:0]       r_tmo_cnt;
    logic                     r_clk_oe;
    logic                     r_data_oe;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;

    ps2_sync u_sync (
        .clk         (clk),
        .clr         (clr),
        .i_ps2_clk   (ps2_clk_i),
        .i_ps2_data  (ps2_data_i),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_clk_fe    (w_clk_fe)
    );

    assign w_active = (r_state == ST_RTS)  || (r_state == ST_SEND) ||
                      (r_state == ST_ACK)  || (r_state == ST_WAIT_IDLE);
    assign w_accept = tx_if.tx_valid && r_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Timeout wins over any edge seen in the same cycle.
            if (w_active && (r_tmo_cnt == c_TMO_LAST)) begin
                r_err     <= 1'b1;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_ready   <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= ST_IDLE;
            end else begin
                if (w_active) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_shift   <= tx_if.tx_data;
                            r_parity  <= odd_parity(tx_if.tx_data);
                            r_inh_cnt <= '0;
                            r_clk_oe  <= 1'b1;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (r_inh_cnt == c_INH_LAST) begin
                            r_clk_oe  <= 1'b0;
                            r_data_oe <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_state   <= ST_RTS;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                    end
                    ST_RTS: begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (w_clk_fe) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt < c_BIT_PARITY) begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= {1'b0, r_shift[7:1]};
                            end else if (r_bit_cnt == c_BIT_PARITY) begin
                                r_data_oe <= ~r_parity;
                            end else begin
                                r_data_oe <= 1'b0;
                                r_state   <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_clk_fe) begin
                            if (!w_data_sync) begin
                                r_state <= ST_WAIT_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_clk_sync && w_data_sync) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_oe     = r_clk_oe;
    assign ps2_data_oe    = r_data_oe;
    assign tx_if.tx_ready = r_ready;
    assign tx_if.busy     = r_busy;
    assign tx_if.done     = r_done;
    assign tx_if.err      = r_err;

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 5000, clock cycles ps2 clock held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 750000, clock cycles allowed from request-to-send to line-idle (15 ms at 50 MHz).
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 clr  in  1  reset; synchronous, active-high.
REQ-005 ps2_clk_i  in  1  sampled PS/2 clock line (asynchronous).
REQ-006 ps2_data_i  in  1  sampled PS/2 data line (asynchronous).
REQ-007 ps2_clk_oe  out  1  1 = drive PS/2 clock low (open-drain).
REQ-008 ps2_data_oe  out  1  1 = drive PS/2 data low (open-drain).
REQ-009 tx_data  in  8  command/argument byte to send to device.
REQ-010 tx_valid  in  1  request; byte accepted when tx_valid and tx_ready both high on a rising edge.
REQ-011 tx_ready  out  1  high only in IDLE.
REQ-012 done  out  1  one-cycle pulse: byte sent and device ack received.
REQ-013 err  out  1  one-cycle pulse: timeout or missing ack.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 ps2_clk_i and ps2_data_i SHALL pass through two flip-flops; a device falling edge (fe) is synchronized clock 1 then 0 on consecutive cycles.
REQ-016 States: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE; transitions only on clk rising edge.
REQ-017 IDLE: on handshake, latch tx_data into shift register, compute odd parity (~^tx_data), go INHIBIT; input ignored otherwise.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYC cycles, then RTS.
REQ-019 RTS: ps2_data_oe=1 (start bit), ps2_clk_oe=0, one cycle, then SEND with bit counter 0.
REQ-020 SEND: on each fe, present next bit: fe 1..8 -> D0..D7 (LSB first), fe 9 -> parity, fe 10 -> stop (ps2_data_oe=0); ps2_data_oe = ~bit; after fe 10 go ACK.
REQ-021 ACK: on next fe, synchronized data 0 -> WAIT_IDLE; data 1 -> err pulse, IDLE.
REQ-022 WAIT_IDLE: when synchronized clock and data both 1 -> done pulse, IDLE.
REQ-023 Timeout counter SHALL clear on entry to RTS and count each cycle in RTS/SEND/ACK/WAIT_IDLE; reaching TIMEOUT_CYC -> err pulse, release both lines, IDLE; timeout takes priority over a simultaneous fe.
REQ-024 done and err SHALL never assert in the same cycle; each lasts exactly one cycle.
REQ-025 ps2_clk_oe SHALL be 1 only in INHIBIT; ps2_data_oe 0 in IDLE, INHIBIT, ACK, WAIT_IDLE.
REQ-026 Device traffic (clock edges) while IDLE SHALL be ignored; a receiver owns that path.
REQ-027 tx_data changes after acceptance SHALL not affect the byte in flight.

Reset
REQ-028 clr high on a rising edge: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0, counters and shift register 0.
REQ-029 clr mid-transfer SHALL release both lines on the next edge; no done/err pulse issued for the aborted byte.
REQ-030 clr SHALL dominate tx_valid in the same cycle; no byte accepted.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, bit-count width, and default INHIBIT_CYC/TIMEOUT_CYC constants, shared with the keyboard receive path.
REQ-032 One sub-module, ps2_sync: two-flop synchronizer for clock and data plus falling-edge detector; reusable by the receiver.

Verification
REQ-033 tx_data=0xED, device model clocks at 12 kHz, acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done one pulse; err never.
REQ-034 tx_data=0x07 -> parity bit 0 observed at fe 9; done pulse.
REQ-035 Device generates no clock -> err exactly TIMEOUT_CYC cycles after RTS entry; both oe 0; tx_ready 1 next cycle.
REQ-036 Device leaves data high at ack fe -> err pulse, no done, IDLE.
REQ-037 clr asserted after fe 4 of byte 0xF4 -> both oe 0 next cycle, no pulse; following 0xF4 request completes with done.
REQ-038 tx_valid held high with 0xAA during transfer of 0xED -> only 0xED sent; 0xAA accepted after return to IDLE.
